disp_regctrl: RTL and testbench



---
 rtl/disp_pkg.sv | 30 +++
 rtl/disp_regctrl_if.sv | 15 +
 rtl/disp_sticky_bit.sv | 25 ++
 rtl/disp_regctrl.sv | 96 +++++++++
 tb/tb_disp_regctrl.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/disp_pkg.sv
// Shared register map, bit positions and helpers for the display register/interrupt block.
package disp_pkg;

  localparam logic [15:0] DISPADDR = 16'h0000;
  localparam logic [15:0] DISPCTRL = 16'h0004;
  localparam logic [15:0] DISPINT  = 16'h0008;
  localparam logic [15:0] DISPFIFO = 16'h000C;

  localparam int unsigned DISPON_B  = 0;
  localparam int unsigned VBLANK_B  = 1;
  localparam int unsigned INTENBL_B = 0;
  localparam int unsigned INTPEND_B = 1;
  localparam int unsigned UNDER_B   = 0;
  localparam int unsigned OVER_B    = 1;

  localparam logic [31:0] P_ADDR_RST = 32'h2000_0000;

  // Replace only the bytes whose enable bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/disp_regctrl_if.sv
// Simple register bus: independent write and read channels, registered read data.
interface disp_regctrl_if #(
  parameter int unsigned AW = 16
);
  logic [AW-1:0] WRADDR;
  logic [3:0]    BYTEEN;
  logic          WREN;
  logic [31:0]   WDATA;
  logic [AW-1:0] RDADDR;
  logic          RDEN;
  logic [31:0]   RDATA;

  modport master (output WRADDR, BYTEEN, WREN, WDATA, RDADDR, RDEN, input RDATA);
  modport slave  (input WRADDR, BYTEEN, WREN, WDATA, RDADDR, RDEN, output RDATA);
endinterface

// File: rtl/disp_sticky_bit.sv
// Sticky status bit: set by an event pulse, write-1-clear, set wins a collision.
module disp_sticky_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic clr,
  output logic q
);
  logic q_q, q_d;

  always_comb begin
    // NOTE: default assigned first so every path drives q_d and no latch is inferred.
    q_d = q_q;
    if (set)      q_d = 1'b1;
    else if (clr) q_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignment so all flops sample pre-edge values together.
    if (!rst_n) q_q <= 1'b0;
    else        q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/disp_regctrl.sv
// Display register decode: frame base address shadow/active pair, control, sticky
// VBLANK/FIFO status and the level interrupt.
module disp_regctrl #(
  parameter int unsigned P_REG_AW   = 16,
  parameter logic [31:0] P_ADDR_RST = disp_pkg::P_ADDR_RST
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  disp_regctrl_if.slave        bus,
  input  logic                 VBLANK_PLS,
  input  logic                 FIFO_OVER_PLS,
  input  logic                 FIFO_UNDER_PLS,
  output logic                 DISPON,
  output logic [31:0]          DISP_ADDR,
  output logic                 DSP_IRQ
);
  import disp_pkg::*;

  logic [31:0] dispaddr_q, dispaddr_d;
  logic [31:0] disp_addr_q, disp_addr_d;
  logic        dispon_q, dispon_d;
  logic        intenbl_q, intenbl_d;
  logic        irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d;

  logic wr_addr, wr_ctrl0, wr_int0, wr_fifo0;
  logic vblank_bit, intpend_bit, under_bit, over_bit;
  logic [31:0] rd_val;

  // Sticky bits all live in byte 0, so their W1C clears need BYTEEN[0].
  always_comb begin
    wr_addr  = bus.WREN && (bus.WRADDR == P_REG_AW'(DISPADDR));
    wr_ctrl0 = bus.WREN && bus.BYTEEN[0] && (bus.WRADDR == P_REG_AW'(DISPCTRL));
    wr_int0  = bus.WREN && bus.BYTEEN[0] && (bus.WRADDR == P_REG_AW'(DISPINT));
    wr_fifo0 = bus.WREN && bus.BYTEEN[0] && (bus.WRADDR == P_REG_AW'(DISPFIFO));
  end

  disp_sticky_bit u_vblank (.clk(ACLK), .rst_n(ARESETN), .set(VBLANK_PLS),
                            .clr(wr_ctrl0 && bus.WDATA[VBLANK_B]), .q(vblank_bit));
  disp_sticky_bit u_intpend (.clk(ACLK), .rst_n(ARESETN), .set(VBLANK_PLS),
                             .clr(wr_int0 && bus.WDATA[INTPEND_B]), .q(intpend_bit));
  disp_sticky_bit u_under (.clk(ACLK), .rst_n(ARESETN), .set(FIFO_UNDER_PLS),
                           .clr(wr_fifo0 && bus.WDATA[UNDER_B]), .q(under_bit));
  disp_sticky_bit u_over (.clk(ACLK), .rst_n(ARESETN), .set(FIFO_OVER_PLS),
                          .clr(wr_fifo0 && bus.WDATA[OVER_B]), .q(over_bit));

  // Read mux uses current register values, so a same-cycle write is not visible.
  always_comb begin
    rd_val = '0;
    if (bus.RDADDR == P_REG_AW'(DISPADDR)) begin
      rd_val = dispaddr_q;
    end else if (bus.RDADDR == P_REG_AW'(DISPCTRL)) begin
      rd_val[DISPON_B] = dispon_q;
      rd_val[VBLANK_B] = vblank_bit;
    end else if (bus.RDADDR == P_REG_AW'(DISPINT)) begin
      rd_val[INTENBL_B] = intenbl_q;
      rd_val[INTPEND_B] = intpend_bit;
    end else if (bus.RDADDR == P_REG_AW'(DISPFIFO)) begin
      rd_val[UNDER_B] = under_bit;
      rd_val[OVER_B]  = over_bit;
    end
  end

  always_comb begin
    dispaddr_d  = wr_addr ? byte_merge(dispaddr_q, bus.WDATA, bus.BYTEEN) : dispaddr_q;
    // The active address takes the post-write shadow so a same-cycle write is not missed.
    disp_addr_d = VBLANK_PLS ? dispaddr_d : disp_addr_q;
    dispon_d    = wr_ctrl0 ? bus.WDATA[DISPON_B] : dispon_q;
    intenbl_d   = wr_int0 ? bus.WDATA[INTENBL_B] : intenbl_q;
    irq_d       = intpend_bit && intenbl_q;
    rdata_d     = bus.RDEN ? rd_val : rdata_q;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      dispaddr_q  <= P_ADDR_RST;
      disp_addr_q <= P_ADDR_RST;
      dispon_q    <= 1'b0;
      intenbl_q   <= 1'b0;
      irq_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      dispaddr_q  <= dispaddr_d;
      disp_addr_q <= disp_addr_d;
      dispon_q    <= dispon_d;
      intenbl_q   <= intenbl_d;
      irq_q       <= irq_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.RDATA = rdata_q;
  assign DISPON    = dispon_q;
  assign DISP_ADDR = disp_addr_q;
  assign DSP_IRQ   = irq_q;
endmodule

// File: tb/tb_disp_regctrl.sv
// Self-checking bench for disp_regctrl: directed vectors, corner sequences and a
// randomized run against a register-level reference model.
module tb_disp_regctrl;
  import disp_pkg::*;

  logic ACLK, ARESETN;
  logic VBLANK_PLS, FIFO_OVER_PLS, FIFO_UNDER_PLS;
  logic DISPON, DSP_IRQ;
  logic [31:0] DISP_ADDR;
  logic [31:0] rd_data;

  int checks = 0;
  int errors = 0;

  disp_regctrl_if #(.AW(16)) bus_if ();

  disp_regctrl #(.P_REG_AW(16), .P_ADDR_RST(32'h2000_0000)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .bus(bus_if),
    .VBLANK_PLS(VBLANK_PLS), .FIFO_OVER_PLS(FIFO_OVER_PLS), .FIFO_UNDER_PLS(FIFO_UNDER_PLS),
    .DISPON(DISPON), .DISP_ADDR(DISP_ADDR), .DSP_IRQ(DSP_IRQ)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] exp_rd;
  } vec_t;

  // Reference model state: register contents as seen by software.
  logic [31:0] m_shadow, m_active, m_rdata;
  logic m_dispon, m_vblank, m_inten, m_pend, m_under, m_over, m_irq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [3:0] be, input logic [31:0] data);
    bus_if.WRADDR = addr;
    bus_if.BYTEEN = be;
    bus_if.WDATA  = data;
    bus_if.WREN   = 1'b1;
    tick();
    bus_if.WREN   = 1'b0;
  endtask

  task automatic rd(input logic [15:0] addr, output logic [31:0] data);
    bus_if.RDADDR = addr;
    bus_if.RDEN   = 1'b1;
    tick();
    bus_if.RDEN   = 1'b0;
    data = bus_if.RDATA;
  endtask

  task automatic pulse_vblank();
    VBLANK_PLS = 1'b1;
    tick();
    VBLANK_PLS = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [15:0] addr);
    case (addr)
      16'h0000: return m_shadow;
      16'h0004: return {30'd0, m_vblank, m_dispon};
      16'h0008: return {30'd0, m_pend, m_inten};
      16'h000C: return {30'd0, m_over, m_under};
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h0004;
      2: return 16'h0008;
      3: return 16'h000C;
      4: return 16'h0010;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    vec_t vecs[5];
    logic [31:0] mask;
    logic [15:0] waddr, raddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic wren, rden, vb, ov, un;

    vecs[0] = '{16'h0000, 4'b0001, 32'h1234_5678, 32'h2000_0078};
    vecs[1] = '{16'h0000, 4'b0010, 32'h0000_5600, 32'h2000_5678};
    vecs[2] = '{16'h0000, 4'b0100, 32'h0034_0000, 32'h2034_5678};
    vecs[3] = '{16'h0000, 4'b1000, 32'h1200_0000, 32'h1234_5678};
    vecs[4] = '{16'h0010, 4'b1111, 32'hFFFF_FFFF, 32'h1234_5678};

    ARESETN = 1'b0;
    VBLANK_PLS = 1'b0; FIFO_OVER_PLS = 1'b0; FIFO_UNDER_PLS = 1'b0;
    bus_if.WRADDR = '0; bus_if.BYTEEN = '0; bus_if.WREN = 1'b0; bus_if.WDATA = '0;
    bus_if.RDADDR = '0; bus_if.RDEN = 1'b0;
    #12;
    check("rst_rdata", bus_if.RDATA, 32'h0);
    check("rst_disp_addr", DISP_ADDR, 32'h2000_0000);
    check("rst_dispon", 32'(DISPON), 32'h0);
    check("rst_irq", 32'(DSP_IRQ), 32'h0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    tick();

    // Byte-granular shadow writes; active address must not follow until VBLANK.
    for (int i = 0; i < 5; i++) begin
      wr(vecs[i].addr, vecs[i].be, vecs[i].data);
      rd(DISPADDR, rd_data);
      check($sformatf("vec%0d_dispaddr", i), rd_data, vecs[i].exp_rd);
      check($sformatf("vec%0d_disp_addr", i), DISP_ADDR, 32'h2000_0000);
    end

    wr(DISPADDR, 4'hF, 32'h2012_C000);
    pulse_vblank();
    check("vblank_load", DISP_ADDR, 32'h2012_C000);

    bus_if.WRADDR = DISPADDR; bus_if.BYTEEN = 4'hF; bus_if.WDATA = 32'h2025_8000;
    bus_if.WREN = 1'b1; VBLANK_PLS = 1'b1;
    tick();
    bus_if.WREN = 1'b0; VBLANK_PLS = 1'b0;
    check("vblank_same_cycle_write", DISP_ADDR, 32'h2025_8000);

    wr(DISPCTRL, 4'b0001, 32'h3);
    check("dispon_set", 32'(DISPON), 32'h1);
    wr(DISPINT, 4'b0001, 32'h3);
    pulse_vblank();
    check("irq_not_yet", 32'(DSP_IRQ), 32'h0);
    tick();
    check("irq_two_after_pulse", 32'(DSP_IRQ), 32'h1);
    rd(DISPCTRL, rd_data);
    check("dispctrl_rd", rd_data, 32'h3);
    rd(DISPINT, rd_data);
    check("dispint_rd", rd_data, 32'h3);

    wr(DISPINT, 4'b0001, 32'h3);
    tick();
    check("irq_cleared", 32'(DSP_IRQ), 32'h0);
    rd(DISPINT, rd_data);
    check("dispint_after_clr", rd_data, 32'h1);

    wr(DISPINT, 4'b0001, 32'h0);
    pulse_vblank();
    tick();
    tick();
    check("irq_masked", 32'(DSP_IRQ), 32'h0);
    rd(DISPINT, rd_data);
    check("dispint_masked_pend", rd_data, 32'h2);
    wr(DISPINT, 4'b0001, 32'h0);
    rd(DISPINT, rd_data);
    check("write0_no_clear", rd_data, 32'h2);

    FIFO_OVER_PLS = 1'b1; FIFO_UNDER_PLS = 1'b1;
    tick();
    FIFO_OVER_PLS = 1'b0; FIFO_UNDER_PLS = 1'b0;
    rd(DISPFIFO, rd_data);
    check("fifo_both", rd_data, 32'h3);
    bus_if.WRADDR = DISPFIFO; bus_if.BYTEEN = 4'b0001; bus_if.WDATA = 32'h3;
    bus_if.WREN = 1'b1; FIFO_OVER_PLS = 1'b1;
    tick();
    bus_if.WREN = 1'b0; FIFO_OVER_PLS = 1'b0;
    rd(DISPFIFO, rd_data);
    check("fifo_set_wins", rd_data, 32'h2);
    wr(DISPFIFO, 4'b1110, 32'h3);
    rd(DISPFIFO, rd_data);
    check("fifo_w1c_needs_be0", rd_data, 32'h2);

    rd(16'h0010, rd_data);
    check("unmapped_rd", rd_data, 32'h0);

    bus_if.WRADDR = DISPADDR; bus_if.BYTEEN = 4'hF; bus_if.WDATA = 32'hDEAD_BEEF;
    bus_if.WREN = 1'b1; bus_if.RDADDR = DISPADDR; bus_if.RDEN = 1'b1;
    tick();
    bus_if.WREN = 1'b0; bus_if.RDEN = 1'b0;
    check("rd_wr_collision_old", bus_if.RDATA, 32'h2025_8000);
    rd(DISPADDR, rd_data);
    check("rd_after_collision", rd_data, 32'hDEAD_BEEF);
    check("rdata_holds", bus_if.RDATA, 32'hDEAD_BEEF);

    // Pending is still set; enabling it raises the interrupt before reset hits.
    wr(DISPINT, 4'b0001, 32'h1);
    tick();
    check("irq_before_reset", 32'(DSP_IRQ), 32'h1);
    @(posedge ACLK);
    #3;
    ARESETN = 1'b0;
    #1;
    check("async_rst_rdata", bus_if.RDATA, 32'h0);
    check("async_rst_disp_addr", DISP_ADDR, 32'h2000_0000);
    check("async_rst_dispon", 32'(DISPON), 32'h0);
    check("async_rst_irq", 32'(DSP_IRQ), 32'h0);
    VBLANK_PLS = 1'b1; FIFO_OVER_PLS = 1'b1; FIFO_UNDER_PLS = 1'b1;
    @(posedge ACLK);
    #1;
    VBLANK_PLS = 1'b0; FIFO_OVER_PLS = 1'b0; FIFO_UNDER_PLS = 1'b0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    tick();
    rd(DISPCTRL, rd_data);
    check("rst_drop_vblank", rd_data, 32'h0);
    rd(DISPFIFO, rd_data);
    check("rst_drop_fifo", rd_data, 32'h0);
    rd(DISPADDR, rd_data);
    check("rst_dispaddr", rd_data, 32'h2000_0000);

    m_shadow = 32'h2000_0000; m_active = 32'h2000_0000; m_rdata = 32'h2000_0000;
    m_dispon = 1'b0; m_vblank = 1'b0; m_inten = 1'b0; m_pend = 1'b0;
    m_under = 1'b0; m_over = 1'b0; m_irq = 1'b0;

    for (int n = 0; n < 600; n++) begin
      wren  = ($urandom_range(0, 1) == 1);
      rden  = ($urandom_range(0, 1) == 1);
      waddr = pick_addr();
      raddr = pick_addr();
      be    = 4'($urandom);
      wdata = $urandom;
      vb    = ($urandom_range(0, 3) == 0);
      ov    = ($urandom_range(0, 4) == 0);
      un    = ($urandom_range(0, 4) == 0);
      bus_if.WRADDR = waddr; bus_if.BYTEEN = be; bus_if.WDATA = wdata; bus_if.WREN = wren;
      bus_if.RDADDR = raddr; bus_if.RDEN = rden;
      VBLANK_PLS = vb; FIFO_OVER_PLS = ov; FIFO_UNDER_PLS = un;
      tick();

      if (rden) m_rdata = model_read(raddr);
      m_irq = m_pend & m_inten;
      if (wren) begin
        if (waddr == 16'h0000) begin
          mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
          m_shadow = (m_shadow & ~mask) | (wdata & mask);
        end else if (be[0]) begin
          if (waddr == 16'h0004) begin
            m_dispon = wdata[0];
            if (wdata[1]) m_vblank = 1'b0;
          end else if (waddr == 16'h0008) begin
            m_inten = wdata[0];
            if (wdata[1]) m_pend = 1'b0;
          end else if (waddr == 16'h000C) begin
            if (wdata[0]) m_under = 1'b0;
            if (wdata[1]) m_over = 1'b0;
          end
        end
      end
      if (vb) begin
        m_vblank = 1'b1;
        m_pend   = 1'b1;
        m_active = m_shadow;
      end
      if (ov) m_over = 1'b1;
      if (un) m_under = 1'b1;

      check("rand_rdata", bus_if.RDATA, m_rdata);
      check("rand_disp_addr", DISP_ADDR, m_active);
      check("rand_dispon", 32'(DISPON), 32'(m_dispon));
      check("rand_irq", 32'(DSP_IRQ), 32'(m_irq));
    end

    bus_if.WREN = 1'b0; bus_if.RDEN = 1'b0;
    VBLANK_PLS = 1'b0; FIFO_OVER_PLS = 1'b0; FIFO_UNDER_PLS = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
